minimig_m68k_bus_master: RTL and testbench

//  68000-style bus initiator: turns a simple request/ack command port (host or DMA side) into a full asynchronous
//  68000 bus cycle (S0-S7: /AS, /UDS, /LDS, R/W, address, data) and waits for /DTACK from the responding bridge.

---
 rtl/minimig_m68k_bus_master_pkg.sv | 19 +
 rtl/minimig_m68k_bus_master_if.sv | 35 +++
 rtl/minimig_m68k_bus_master_wdog.sv | 25 ++
 rtl/minimig_m68k_bus_master.sv | 123 ++++++++++++
 tb/tb_minimig_m68k_bus_master.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/minimig_m68k_bus_master_pkg.sv
// Shared types and defaults for the 68000-style bus initiator.
package minimig_m68k_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_S6,
    ST_S7,
    ST_DONE
  } state_t;

  localparam int TIMEOUT_DEF = 256;
  localparam int TO_W_DEF    = 9;

endpackage

// File: rtl/minimig_m68k_bus_master_if.sv
// Command port plus 68000 bus pins; master = initiator side, slave = host/bridge side.
interface minimig_m68k_bus_master_if;

  logic        req;
  logic        we;
  logic [1:0]  bs;
  logic [23:1] adr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        ack;
  logic        err;
  logic        busy;

  logic        _as;
  logic        _uds;
  logic        _lds;
  logic        r_w;
  logic [23:1] address;
  logic [15:0] data_out;
  logic        data_oe;
  logic [15:0] data_in;
  logic        _dtack;
  logic        _berr;

  modport master (
    input  req, we, bs, adr, wdat, data_in, _dtack, _berr,
    output rdat, ack, err, busy, _as, _uds, _lds, r_w, address, data_out, data_oe
  );

  modport slave (
    output req, we, bs, adr, wdat, data_in, _dtack, _berr,
    input  rdat, ack, err, busy, _as, _uds, _lds, r_w, address, data_out, data_oe
  );

endinterface

// File: rtl/minimig_m68k_bus_master_wdog.sv
// Wait-state counter for S4; hit fires on the increment that reaches TIMEOUT.
module minimig_m68k_wdog #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // TIMEOUT of zero disables the abort entirely
  assign hit = (TIMEOUT != 0) && inc && ((int'(cnt) + 1) == TIMEOUT);

endmodule

// File: rtl/minimig_m68k_bus_master.sv
// 68000 bus-cycle initiator: request/ack command port in, S1..S7 bus sequence out, /DTACK, /BERR, watchdog.
module minimig_m68k_bus_master
  import minimig_m68k_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                     clk,
  input  logic                     _reset,
  input  logic                     clk7_en,
  input  logic                     clk7n_en,
  minimig_m68k_bus_master_if.master bus
);

  state_t     state;
  logic       we_l;
  logic [1:0] bs_l;
  logic       abort;
  logic       wd_clr;
  logic       wd_inc;
  logic       wd_hit;

  // counter idles at zero until a cycle starts; only a quiet S4 sample counts as a wait
  assign wd_clr = (state == ST_IDLE) || (state == ST_DONE);
  assign wd_inc = (state == ST_S4) && clk7n_en && !clk7_en && bus._berr && bus._dtack;

  minimig_m68k_wdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wdog (
    .clk (clk),
    .clr (wd_clr),
    .inc (wd_inc),
    .hit (wd_hit)
  );

  always_ff @(posedge clk) begin
    bus.ack <= 1'b0;
    bus.err <= 1'b0;
    if (!_reset) begin
      state       <= ST_IDLE;
      bus._as     <= 1'b1;
      bus._uds    <= 1'b1;
      bus._lds    <= 1'b1;
      bus.r_w     <= 1'b1;
      bus.data_oe <= 1'b0;
      bus.busy    <= 1'b0;
      bus.rdat    <= '0;
      bus.address <= '0;
      abort       <= 1'b0;
    end else if (clk7_en) begin
      // rising CPU clock: moves into even states
      case (state)
        ST_S1: begin
          state   <= ST_S2;
          bus._as <= 1'b0;
          if (!we_l) begin
            bus._uds <= !bs_l[1];
            bus._lds <= !bs_l[0];
          end
        end
        ST_S3: begin
          state <= ST_S4;
          if (we_l) begin
            bus._uds <= !bs_l[1];
            bus._lds <= !bs_l[0];
          end
        end
        ST_S5: state <= ST_S6;
        ST_S7: begin
          state    <= ST_DONE;
          bus._as  <= 1'b1;
          bus._uds <= 1'b1;
          bus._lds <= 1'b1;
          bus.ack  <= !abort;
          bus.err  <= abort;
        end
        default: ;
      endcase
    end else if (clk7n_en) begin
      // falling CPU clock: moves into odd states; DONE may chain straight into a new S1
      case (state)
        ST_IDLE, ST_DONE: begin
          state       <= ST_IDLE;
          bus.r_w     <= 1'b1;
          bus.data_oe <= 1'b0;
          bus.busy    <= 1'b0;
          if (bus.req) begin
            state        <= ST_S1;
            bus.busy     <= 1'b1;
            we_l         <= bus.we;
            bs_l         <= bus.bs;
            bus.address  <= bus.adr;
            bus.data_out <= bus.wdat;
            bus.r_w      <= !bus.we;
            abort        <= 1'b0;
          end
        end
        ST_S2: begin
          state <= ST_S3;
          if (we_l) bus.data_oe <= 1'b1;
        end
        ST_S4: begin
          if (!bus._berr) begin
            state <= ST_S7;
            abort <= 1'b1;
          end else if (!bus._dtack) begin
            state <= ST_S5;
          end else if (wd_hit) begin
            state <= ST_S7;
            abort <= 1'b1;
          end
        end
        ST_S6: begin
          state <= ST_S7;
          if (!we_l && !abort) bus.rdat <= bus.data_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minimig_m68k_bus_master.sv
// Bench for minimig_m68k_bus_master: directed vector table, randomized transactions, reset and back-to-back sequences.
module tb_minimig_m68k_bus_master;

  localparam int TO      = 4;
  localparam int M_DTACK = 0;
  localparam int M_BERR  = 1;
  localparam int M_BOTH  = 2;
  localparam int M_NONE  = 3;

  typedef struct {
    logic        we;
    logic [1:0]  bs;
    logic [23:1] adr;
    logic [15:0] wdat;
    logic [15:0] din;
    int          w;
    int          mode;
    logic        exp_ok;
    int          exp_lat;
    logic [15:0] exp_rdat;
  } vec_t;

  logic        clk = 1'b0;
  logic        _reset;
  logic [1:0]  ph = 2'd0;
  logic        clk7_en;
  logic        clk7n_en;
  int          n_chk = 0;
  int          n_fail = 0;
  int          rsp_w = 0;
  int          rsp_mode = M_NONE;
  int          rcnt = 0;
  logic [15:0] rdat_model;

  minimig_m68k_bus_master_if bus ();

  minimig_m68k_bus_master #(
    .TIMEOUT (TO),
    .TO_W    (9)
  ) dut (
    .clk      (clk),
    ._reset   (_reset),
    .clk7_en  (clk7_en),
    .clk7n_en (clk7n_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign clk7n_en = (ph == 2'd0);
  assign clk7_en  = (ph == 2'd2);

  // Responder: counts CPU falling edges since /AS fell, answers after the programmed wait count
  always @(posedge clk) begin
    if (bus._as) rcnt = 0;
    else if (clk7n_en) rcnt = rcnt + 1;
  end

  always @(negedge clk) begin
    bus._dtack = !(!bus._as && rsp_mode != M_NONE && rcnt >= rsp_w + 1 &&
                   (rsp_mode == M_DTACK || rsp_mode == M_BOTH));
    bus._berr  = !(!bus._as && rsp_mode != M_NONE && rcnt >= rsp_w + 1 &&
                   (rsp_mode == M_BERR || rsp_mode == M_BOTH));
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] bs, input logic [23:1] adr,
                              input logic [15:0] wdat, input logic [15:0] din, input int w,
                              input int mode, input logic ok, input int lat, input logic [15:0] rd);
    vec_t v;
    v.we = we; v.bs = bs; v.adr = adr; v.wdat = wdat; v.din = din; v.w = w; v.mode = mode;
    v.exp_ok = ok; v.exp_lat = lat; v.exp_rdat = rd;
    return v;
  endfunction

  // Transaction-level model: which S4 sample ends the cycle, and how it ends
  function automatic vec_t model(input vec_t v, input logic [15:0] prev);
    vec_t r;
    int   s;
    r = v;
    if (v.mode != M_NONE && v.w + 1 <= TO) begin
      s = v.w + 1;
      r.exp_ok = (v.mode == M_DTACK);
    end else begin
      s = TO;
      r.exp_ok = 1'b0;
    end
    r.exp_lat  = r.exp_ok ? 5 + 2 * s : 3 + 2 * s;
    r.exp_rdat = (r.exp_ok && !v.we) ? v.din : prev;
    return r;
  endfunction

  task automatic align();
    do @(negedge clk); while (ph != 2'd0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) check("idle_wait", bus.busy, 0);
  endtask

  task automatic drive(input vec_t v);
    bus.we = v.we; bus.bs = v.bs; bus.adr = v.adr; bus.wdat = v.wdat; bus.data_in = v.din;
    rsp_w = v.w; rsp_mode = v.mode;
    bus.req = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   n, as_n, oe_n, st_n, st_exp;
    logic addr_ok, rw_ok, busy_ok, oe_ok, dout_ok, saw_u, saw_l, done, got_ack, got_err;
    wait_idle();
    align();
    drive(v);
    n = 0; as_n = 0; oe_n = 0; st_n = 0;
    addr_ok = 1; rw_ok = 1; busy_ok = 1; oe_ok = 1; dout_ok = 1; saw_u = 0; saw_l = 0; done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.address !== v.adr) addr_ok = 0;
      if (bus.r_w !== !v.we) rw_ok = 0;
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (!bus._as && as_n == 0) as_n = n;
      if (bus.data_oe && oe_n == 0) oe_n = n;
      if (bus.data_oe && bus.data_out !== v.wdat) dout_ok = 0;
      if ((!bus._uds || !bus._lds) && st_n == 0) st_n = n;
      if (!bus._uds) saw_u = 1;
      if (!bus._lds) saw_l = 1;
      if ((!bus._uds || !bus._lds) && bus.data_oe !== v.we) oe_ok = 0;
      if (bus.data_oe && !v.we) oe_ok = 0;
      if (bus.ack || bus.err) done = 1;
    end
    got_ack = bus.ack;
    got_err = bus.err;
    check({tag, "_done"}, done, 1);
    check({tag, "_ack"}, got_ack, v.exp_ok);
    check({tag, "_err"}, got_err, !v.exp_ok);
    check({tag, "_latency"}, (n - 1) / 2, v.exp_lat);
    check({tag, "_strobes_off"}, {bus._as, bus._uds, bus._lds}, 3'b111);
    check({tag, "_rdat"}, bus.rdat, v.exp_rdat);
    check({tag, "_addr_rw_busy"}, {addr_ok, rw_ok, busy_ok}, 3'b111);
    check({tag, "_oe_order"}, {oe_ok, dout_ok}, 2'b11);
    check({tag, "_strobe_set"}, {saw_u, saw_l}, v.bs);
    check({tag, "_as_time"}, as_n, 3);
    st_exp = (v.bs == 2'b00) ? 0 : (v.we ? 7 : 3);
    check({tag, "_strobe_time"}, st_n, st_exp);
    check({tag, "_oe_time"}, oe_n, v.we ? 5 : 0);
    bus.req = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_width"}, {bus.ack, bus.err}, 2'b00);
  endtask

  vec_t tbl[9];
  vec_t v, v2;
  int   n, k;
  logic seen;

  initial begin
    _reset = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.bs = 2'b00; bus.adr = '0; bus.wdat = '0; bus.data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {bus._as, bus._uds, bus._lds}, 3'b111);
    check("rst_rw_oe", {bus.r_w, bus.data_oe}, 2'b10);
    check("rst_ack_err_busy", {bus.ack, bus.err, bus.busy}, 3'b000);
    check("rst_rdat", bus.rdat, 16'h0000);
    check("rst_address", bus.address, 23'h0);
    _reset = 1'b1;
    rdat_model = 16'h0000;

    tbl[0] = mk(0, 2'b11, 23'h0BFE01, 16'h0000, 16'hA55A, 0, M_DTACK, 1, 7,  16'hA55A);
    tbl[1] = mk(1, 2'b10, 23'h000100, 16'h1234, 16'h0000, 3, M_DTACK, 1, 13, 16'hA55A);
    tbl[2] = mk(0, 2'b01, 23'h7FFFFF, 16'h0000, 16'h0F0F, 1, M_DTACK, 1, 9,  16'h0F0F);
    tbl[3] = mk(0, 2'b11, 23'h001234, 16'h0000, 16'hFFFF, 0, M_BOTH,  0, 5,  16'h0F0F);
    tbl[4] = mk(0, 2'b11, 23'h002000, 16'h0000, 16'h1111, 0, M_NONE,  0, 11, 16'h0F0F);
    tbl[5] = mk(1, 2'b00, 23'h003000, 16'hBEEF, 16'h0000, 0, M_DTACK, 1, 7,  16'h0F0F);
    tbl[6] = mk(0, 2'b10, 23'h004000, 16'h0000, 16'h2222, 2, M_BERR,  0, 9,  16'h0F0F);
    tbl[7] = mk(0, 2'b11, 23'h005000, 16'h0000, 16'hC0DE, 3, M_DTACK, 1, 13, 16'hC0DE);
    tbl[8] = mk(1, 2'b01, 23'h006000, 16'h5AA5, 16'h0000, 4, M_DTACK, 0, 11, 16'hC0DE);
    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      rdat_model = tbl[i].exp_rdat;
    end

    for (int i = 0; i < 24; i++) begin
      v.we   = 1'($urandom_range(0, 1));
      v.bs   = 2'($urandom_range(0, 3));
      v.adr  = 23'($urandom);
      v.wdat = 16'($urandom);
      v.din  = 16'($urandom);
      v.w    = $urandom_range(0, 5);
      k      = $urandom_range(0, 9);
      v.mode = (k == 6) ? M_BERR : (k == 7) ? M_BOTH : (k == 8) ? M_NONE : M_DTACK;
      v = model(v, rdat_model);
      run_vec(v, $sformatf("rnd%0d", i));
      rdat_model = v.exp_rdat;
    end

    // Reset while a write sits in its wait state
    wait_idle();
    align();
    drive(mk(1, 2'b11, 23'h00ABCD, 16'h7777, 16'h0000, 0, M_NONE, 0, 0, 16'h0000));
    repeat (8) @(negedge clk);
    check("rstmid_in_s4", {bus.data_oe, bus._uds, bus._lds, bus._as}, 4'b1000);
    _reset = 1'b0;
    @(negedge clk);
    check("rstmid_strobes", {bus._as, bus._uds, bus._lds}, 3'b111);
    check("rstmid_rw_oe", {bus.r_w, bus.data_oe}, 2'b10);
    check("rstmid_ack_err_busy", {bus.ack, bus.err, bus.busy}, 3'b000);
    bus.req = 1'b0;
    _reset = 1'b1;
    seen = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (bus.ack || bus.err || !bus._as) seen = 1'b1;
    end
    check("rstmid_quiet", seen, 0);
    rdat_model = 16'h0000;

    // Back-to-back reads with req held across DONE
    wait_idle();
    align();
    drive(mk(0, 2'b11, 23'h010000, 16'h0000, 16'h1357, 0, M_DTACK, 1, 7, 16'h1357));
    n = 0;
    while (!(bus.ack || bus.err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_ack", {bus.ack, bus.err}, 2'b10);
    check("b2b_first_latency", n, 15);
    check("b2b_first_rdat", bus.rdat, 16'h1357);
    v2 = mk(0, 2'b11, 23'h020000, 16'h0000, 16'h2468, 0, M_DTACK, 1, 7, 16'h2468);
    bus.adr = v2.adr;
    bus.data_in = v2.din;
    @(negedge clk);
    check("b2b_addr_hold", bus.address, 23'h010000);
    @(negedge clk);
    check("b2b_addr_switch", {bus.address, bus.busy, bus.r_w}, {23'h020000, 1'b1, 1'b1});
    bus.req = 1'b0;
    n = 0;
    while (!(bus.ack || bus.err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_ack", {bus.ack, bus.err}, 2'b10);
    check("b2b_second_latency", n, 14);
    check("b2b_second_rdat", bus.rdat, v2.exp_rdat);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
